mac_tile_flex: RTL and testbench
================================

Name: mac_tile_flex

Overview:
Parametrised, weight-stationary MAC tile of NLANE lanes, each lane carrying a 2-bit activation slice and a 4-bit weight.
Runtime precision mode fuses adjacent lanes into 4-bit or 8-bit activations.
Two-stage pipelined execute with output valid; forwards activations, weights and instructions east/south for array tiling.
Successor to the 2-lane, 2/4-bit mac_tile.

Parameters:
NLANE, 4, number of lanes; must be a multiple of 4.
a_bw, 2, activation slice width per lane (unsigned).
w_bw, 4, weight width per lane (signed two's complement).
psum_bw, 16, partial-sum width (signed two's complement).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high.
mode  input  2  00 = per-lane 2-bit; 01 = pairs fused (4-bit); 10 = quads fused (8-bit); 11 = reserved, treated as 00.
inst_w  input  2  bit0 = load weights, bit1 = execute.
in_x  input  NLANE*a_bw  activation slices; lane k at [k*a_bw +: a_bw].
in_w  input  NLANE*w_bw  weights; lane k at [k*w_bw +: w_bw].
in_psum  input  NLANE*psum_bw  incoming partial sums, per lane.
out_s  output  NLANE*psum_bw  result partial sums.
out_valid  output  1  out_s updated this cycle.
out_x  output  NLANE*a_bw  registered activation forward.
out_w  output  NLANE*w_bw  registered weight forward.
inst_e  output  2  inst_w delayed one cycle.

Behaviour:
- Reset: clears all of the following, regardless of in-flight operations:
  - weight regs, out_s, out_x, out_w, inst_e;
  - pipeline regs;
  - out_valid = 0.
- Load (inst_w[0]=1): at the edge, weight reg k <= in_w lane k, and out_w <= in_w. Otherwise both hold.
- Execute (inst_w[1]=1) at edge t, stage 1:
  - captures per-lane products, in_psum and mode;
  - out_x <= in_x (otherwise out_x holds).
- Stage 2 at edge t+1: out_s updated and out_valid=1, so results are visible after edge t+1 (latency 2).
- out_valid=0 in any cycle without a completing op; out_s holds its last value.
- Back-to-back executes give one result per cycle.
- Mode is captured per op, so a mode change never corrupts in-flight ops.
- Simultaneous load+execute (inst_w=11): the execute uses the old weights; new weights apply from the next cycle.
- inst_e <= inst_w every cycle.
- Group base lane b: lane index with b mod G = 0, where G = 1, 2 or 4 for mode 00, 01, 10.
- Group activation X = concatenation of the group's slices, lane b least significant (unsigned, a_bw*G bits).
- Group weight = weight reg of lane b; other lanes' weights are ignored in fused modes.
- Lane b: out_s = in_psum_b + sext(W_b * X). Product is computed as signed of width w_bw + a_bw*G + 1.
- Non-base lanes in a group: out_s = their own in_psum, passed through with the same latency.
- Implement the fused product as the sum of slice products shifted by 2*(k-b); it must be bit-exact with W*X.
- Arithmetic wraps modulo 2^psum_bw (no saturation).
- Reset asserted mid-pipeline: the in-flight result is discarded, and out_valid stays 0 until 2 edges after the next execute.

Decomposition:
- Package mac_flex_pkg:
  - mode encodings MODE_LANE2, MODE_PAIR4, MODE_QUAD8;
  - inst bit indices INST_LOAD, INST_EXEC;
  - helper function returning group size G per mode.
- One natural sub-module, mac_lane_mul: signed w_bw × unsigned a_bw slice multiplier, instantiated NLANE times.
- Fusion adder, pipeline and forwarding stay in the top module.

Test Plan:
- Mode 00, NLANE=4:
  - load weights [2,3,-1,5];
  - execute x=[1,2,3,0], psum=[5,10,0,7];
  - expect out_s=[7,16,-3,7] and out_valid=1 exactly 2 edges after the execute edge.
- Mode 01:
  - weights lane0=5, lane2=-2;
  - x=[2,1,3,3] (X0=6, X2=15), psum=[0,4,10,9];
  - expect out_s=[30,4,-20,9].
- Mode 10:
  - weight lane0=7;
  - x=[3,2,1,0] (X=27), psum=[100,1,2,3];
  - expect out_s=[289,1,2,3].
- Wrap:
  - mode 10, weight lane0=-8, x=[3,3,3,3] (X=255), psum0=16'h8000;
  - expect out_s lane0=30728 (16'h7808).
- inst_w=11 with weights 2 loaded and new in_w=3, x=1, psum=0: expect result 2. A following execute with the same inputs gives 3. inst_e mirrors inst_w one cycle late.
- Back-to-back executes with mode switched 00→01 between them: each result matches the mode it was issued with. Reset asserted the cycle after an execute: out_valid never rises and all outputs read 0.

Source files
------------

// File: rtl/mac_flex_pkg.sv
// Shared encodings and helpers for the precision-flexible MAC tile.
package mac_flex_pkg;

    typedef enum logic [1:0] {
        MODE_LANE2 = 2'b00,
        MODE_PAIR4 = 2'b01,
        MODE_QUAD8 = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    localparam int INST_LOAD = 0;
    localparam int INST_EXEC = 1;

    // Reserved mode behaves like per-lane operation.
    function automatic int group_size(input logic [1:0] mode);
        case (mode)
            MODE_PAIR4: return 2;
            MODE_QUAD8: return 4;
            default:    return 1;
        endcase
    endfunction

endpackage

// File: rtl/mac_lane_mul.sv
// Signed weight times unsigned activation slice, full-precision product.
module mac_lane_mul #(
    parameter int a_bw = 2,
    parameter int w_bw = 4
) (
    input  logic [w_bw-1:0]      w,
    input  logic [a_bw-1:0]      x,
    output logic [w_bw+a_bw:0]   p
);
    localparam int PB = w_bw + a_bw + 1;

    logic signed [PB-1:0] w_ext;
    logic signed [PB-1:0] x_ext;

    assign w_ext = PB'($signed(w));
    assign x_ext = PB'({1'b0, x});
    assign p     = w_ext * x_ext;

endmodule

// File: rtl/mac_tile_flex.sv
// Weight-stationary MAC tile with runtime lane fusion (2/4/8-bit activations),
// two-stage execute pipeline and east/south forwarding.
module mac_tile_flex
    import mac_flex_pkg::*;
#(
    parameter int NLANE   = 4,
    parameter int a_bw    = 2,
    parameter int w_bw    = 4,
    parameter int psum_bw = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mode,
    input  logic [1:0]               inst_w,
    input  logic [NLANE*a_bw-1:0]    in_x,
    input  logic [NLANE*w_bw-1:0]    in_w,
    input  logic [NLANE*psum_bw-1:0] in_psum,
    output logic [NLANE*psum_bw-1:0] out_s,
    output logic                     out_valid,
    output logic [NLANE*a_bw-1:0]    out_x,
    output logic [NLANE*w_bw-1:0]    out_w,
    output logic [1:0]               inst_e
);
    localparam int PB = w_bw + a_bw + 1;

    logic [NLANE*w_bw-1:0]    w_reg;
    logic [NLANE*PB-1:0]      prod;
    logic [NLANE*PB-1:0]      prod_q;
    logic [NLANE*psum_bw-1:0] psum_q;
    logic [NLANE*psum_bw-1:0] sum_d;
    logic [1:0]               mode_q;
    logic                     exec_q;

    function automatic logic [psum_bw-1:0] sx(input logic [PB-1:0] p);
        return psum_bw'($signed(p));
    endfunction

    assign out_w = w_reg;

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        localparam int B2 = k - (k % 2);
        localparam int B4 = k - (k % 4);

        logic [w_bw-1:0]    mul_w;
        logic [psum_bw-1:0] fused2;
        logic [psum_bw-1:0] fused4;
        logic [psum_bw-1:0] fuse;

        // Every slice in a fused group multiplies by the base lane's weight.
        always_comb begin
            case (mode)
                MODE_PAIR4: mul_w = w_reg[B2*w_bw +: w_bw];
                MODE_QUAD8: mul_w = w_reg[B4*w_bw +: w_bw];
                default:    mul_w = w_reg[k*w_bw +: w_bw];
            endcase
        end

        mac_lane_mul #(.a_bw(a_bw), .w_bw(w_bw)) u_mul (
            .w (mul_w),
            .x (in_x[k*a_bw +: a_bw]),
            .p (prod[k*PB +: PB])
        );

        if (k % 2 == 0) begin : g_pair
            assign fused2 = sx(prod_q[k*PB +: PB])
                          + (sx(prod_q[(k+1)*PB +: PB]) << a_bw);
        end else begin : g_no_pair
            assign fused2 = '0;
        end

        if (k % 4 == 0) begin : g_quad
            assign fused4 = sx(prod_q[k*PB +: PB])
                          + (sx(prod_q[(k+1)*PB +: PB]) << a_bw)
                          + (sx(prod_q[(k+2)*PB +: PB]) << (2*a_bw))
                          + (sx(prod_q[(k+3)*PB +: PB]) << (3*a_bw));
        end else begin : g_no_quad
            assign fused4 = '0;
        end

        // Non-base lanes see a zero contribution, so their psum passes through.
        always_comb begin
            case (mode_q)
                MODE_PAIR4: fuse = fused2;
                MODE_QUAD8: fuse = fused4;
                default:    fuse = sx(prod_q[k*PB +: PB]);
            endcase
        end

        assign sum_d[k*psum_bw +: psum_bw] = psum_q[k*psum_bw +: psum_bw] + fuse;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_reg     <= '0;
            prod_q    <= '0;
            psum_q    <= '0;
            mode_q    <= '0;
            exec_q    <= 1'b0;
            out_s     <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            inst_e    <= '0;
        end else begin
            inst_e    <= inst_w;
            exec_q    <= inst_w[INST_EXEC];
            out_valid <= exec_q;
            if (inst_w[INST_LOAD]) begin
                w_reg <= in_w;
            end
            if (inst_w[INST_EXEC]) begin
                prod_q <= prod;
                psum_q <= in_psum;
                mode_q <= mode;
                out_x  <= in_x;
            end
            if (exec_q) begin
                out_s <= sum_d;
            end
        end
    end

endmodule

// File: tb/tb_mac_tile_flex.sv
// Self-checking bench for mac_tile_flex (NLANE=4): directed table, random ops
// against an arithmetic reference model, and pipeline corner sequences.
module tb_mac_tile_flex;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [1:0]  inst_w;
    logic [7:0]  in_x;
    logic [15:0] in_w;
    logic [63:0] in_psum;
    logic [63:0] out_s;
    logic        out_valid;
    logic [7:0]  out_x;
    logic [15:0] out_w;
    logic [1:0]  inst_e;

    always #5 clk = ~clk;

    mac_tile_flex #(.NLANE(4), .a_bw(2), .w_bw(4), .psum_bw(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .inst_w    (inst_w),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_psum   (in_psum),
        .out_s     (out_s),
        .out_valid (out_valid),
        .out_x     (out_x),
        .out_w     (out_w),
        .inst_e    (inst_e)
    );

    typedef struct packed {
        logic [1:0]  mode;
        logic [15:0] w;
        logic [7:0]  x;
        logic [63:0] psum;
        logic [63:0] exp;
    } vec_t;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: group value X as a plain integer, weight from the base lane.
    function automatic logic [63:0] model(input logic [1:0] md, input logic [15:0] w,
                                          input logic [7:0] x, input logic [63:0] ps);
        logic [63:0] res;
        int g;
        g = (md == 2'b01) ? 2 : (md == 2'b10) ? 4 : 1;
        for (int k = 0; k < 4; k++) begin
            int r;
            r = int'(ps[k*16 +: 16]);
            if (k % g == 0) begin
                int xv;
                int wv;
                xv = 0;
                for (int j = 0; j < g; j++) xv += int'(x[(k+j)*2 +: 2]) * (1 << (2*j));
                wv = int'($signed(w[k*4 +: 4]));
                r += wv * xv;
            end
            res[k*16 +: 16] = r[15:0];
        end
        return res;
    endfunction

    task automatic load_w(input logic [15:0] w);
        in_w   = w;
        inst_w = 2'b01;
        tick();
        inst_w = 2'b00;
    endtask

    task automatic exec_op(input string name, input logic [1:0] md, input logic [7:0] x,
                           input logic [63:0] ps, input logic [63:0] exp);
        mode    = md;
        in_x    = x;
        in_psum = ps;
        inst_w  = 2'b10;
        tick();
        inst_w = 2'b00;
        check({name, "_valid_early"}, {63'd0, out_valid}, 64'd0);
        check({name, "_out_x"}, {56'd0, out_x}, {56'd0, x});
        tick();
        check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({name, "_out_s"}, out_s, exp);
        tick();
        check({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check({name, "_hold"}, out_s, exp);
    endtask

    vec_t        vecs [4];
    logic [15:0] cur_w;
    logic [63:0] last_s;
    logic        issued [41];
    logic [63:0] expv   [41];
    logic [1:0]  inst_prev;

    initial begin
        vecs[0].mode = 2'b00;
        vecs[0].w    = {4'd5, 4'hF, 4'd3, 4'd2};
        vecs[0].x    = {2'd0, 2'd3, 2'd2, 2'd1};
        vecs[0].psum = {16'd7, 16'd0, 16'd10, 16'd5};
        vecs[0].exp  = {16'd7, 16'hFFFD, 16'd16, 16'd7};

        vecs[1].mode = 2'b01;
        vecs[1].w    = {4'd7, 4'hE, 4'd6, 4'd5};
        vecs[1].x    = {2'd3, 2'd3, 2'd1, 2'd2};
        vecs[1].psum = {16'd9, 16'd10, 16'd4, 16'd0};
        vecs[1].exp  = {16'd9, 16'hFFEC, 16'd4, 16'd30};

        vecs[2].mode = 2'b10;
        vecs[2].w    = {4'd1, 4'd2, 4'd3, 4'd7};
        vecs[2].x    = {2'd0, 2'd1, 2'd2, 2'd3};
        vecs[2].psum = {16'd3, 16'd2, 16'd1, 16'd100};
        vecs[2].exp  = {16'd3, 16'd2, 16'd1, 16'd289};

        vecs[3].mode = 2'b10;
        vecs[3].w    = {4'd0, 4'd0, 4'd0, 4'h8};
        vecs[3].x    = 8'hFF;
        vecs[3].psum = {16'd0, 16'd0, 16'd0, 16'h8000};
        vecs[3].exp  = {16'd0, 16'd0, 16'd0, 16'h7808};

        reset = 1'b1; mode = '0; inst_w = '0; in_x = '0; in_w = '0; in_psum = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_s", out_s, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_x", {56'd0, out_x}, 64'd0);
        check("rst_out_w", {48'd0, out_w}, 64'd0);
        check("rst_inst_e", {62'd0, inst_e}, 64'd0);

        for (int i = 0; i < 4; i++) begin
            load_w(vecs[i].w);
            check($sformatf("vec%0d_out_w", i), {48'd0, out_w}, {48'd0, vecs[i].w});
            exec_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].x, vecs[i].psum, vecs[i].exp);
        end

        for (int i = 0; i < 20; i++) begin
            logic [1:0]  md;
            logic [7:0]  x;
            logic [63:0] ps;
            cur_w = 16'($urandom);
            load_w(cur_w);
            md = 2'($urandom_range(0, 3));
            x  = 8'($urandom);
            ps = {$urandom, $urandom};
            exec_op($sformatf("rand%0d", i), md, x, ps, model(md, cur_w, x, ps));
            last_s = model(md, cur_w, x, ps);
        end

        // Back-to-back stream; first two ops force a 00 -> 01 mode switch.
        inst_prev = 2'b00;
        for (int i = 0; i <= 40; i++) begin
            if (i < 40) begin
                issued[i] = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
                mode    = (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'($urandom_range(0, 3));
                in_x    = 8'($urandom);
                in_psum = {$urandom, $urandom};
                expv[i] = model(mode, cur_w, in_x, in_psum);
                inst_w  = issued[i] ? 2'b10 : 2'b00;
            end else begin
                inst_w = 2'b00;
            end
            inst_prev = inst_w;
            tick();
            check($sformatf("stream%0d_inst_e", i), {62'd0, inst_e}, {62'd0, inst_prev});
            if (i > 0) begin
                check($sformatf("stream%0d_valid", i), {63'd0, out_valid}, {63'd0, issued[i-1]});
                if (issued[i-1]) last_s = expv[i-1];
                check($sformatf("stream%0d_out_s", i), out_s, last_s);
            end
        end

        // Load and execute together: execute sees the previous weights.
        mode = 2'b00;
        load_w(16'h2222);
        in_w = 16'h3333; in_x = 8'h55; in_psum = '0;
        inst_w = 2'b11;
        tick();
        check("ldex_inst_e", {62'd0, inst_e}, 64'd3);
        inst_w = 2'b10;
        tick();
        check("ldex_inst_e2", {62'd0, inst_e}, 64'd2);
        check("ldex_valid", {63'd0, out_valid}, 64'd1);
        check("ldex_old_w", out_s, {16'd2, 16'd2, 16'd2, 16'd2});
        inst_w = 2'b00;
        tick();
        check("ldex_inst_e3", {62'd0, inst_e}, 64'd0);
        check("ldex_new_w", out_s, {16'd3, 16'd3, 16'd3, 16'd3});

        // Reset one cycle after an execute discards the in-flight result.
        in_x = 8'hA5; in_psum = {4{16'h1234}};
        inst_w = 2'b10;
        tick();
        inst_w = 2'b00;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_valid", {63'd0, out_valid}, 64'd0);
        check("mrst_out_s", out_s, 64'd0);
        check("mrst_out_x", {56'd0, out_x}, 64'd0);
        check("mrst_out_w", {48'd0, out_w}, 64'd0);
        check("mrst_inst_e", {62'd0, inst_e}, 64'd0);
        tick();
        check("mrst_valid2", {63'd0, out_valid}, 64'd0);
        check("mrst_out_s2", out_s, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
